// File: rtl/hbm_tg_pkg.sv
// Shared types and constants for the HBM traffic-generator write path.
package hbm_tg_pkg;

  localparam int CNT_W = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } wr_state_e;

  // The engine never issues exclusive accesses, so anything but OKAY is an error.
  function automatic logic is_err_resp(input logic [1:0] resp);
    logic err;
    case (resp)
      AXI_RESP_OKAY:   err = 1'b0;
      AXI_RESP_EXOKAY,
      AXI_RESP_SLVERR,
      AXI_RESP_DECERR: err = 1'b1;
      default:         err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/hbm_credit_ctr.sv
// Saturating 8-bit up/down counter tracking AW bursts awaiting a B response.
module hbm_credit_ctr #(
  parameter int LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] count,
  output logic       at_limit,
  output logic       underflow
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);

  assign at_limit  = (count >= LIMIT_C);
  assign underflow = dec & ~inc & (count == 8'd0);

  // Count up on inc, down on dec; simultaneous inc/dec cancel; clamp at both ends.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= 8'd0;
    end else if (inc && !dec && count != 8'hFF) begin
      count <= count + 8'd1;
    end else if (dec && !inc && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

endmodule

// File: rtl/hbm_write_resp_monitor.sv
// Closes each write test: consumes the B channel, throttles AW issue by credit,
// classifies responses, times the run and reports done/timeout status.
module hbm_write_resp_monitor
  import hbm_tg_pkg::*;
#(
  parameter int ENGINE_ID       = 0,
  parameter int ID_WIDTH        = 5,
  parameter int EXP_BID         = 0,
  parameter int MAX_OUTSTANDING = 64,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_write,
  input  logic [31:0]         write_ops,
  input  logic                aw_fire,
  input  logic                m_axi_BVALID,
  input  logic [1:0]          m_axi_BRESP,
  input  logic [ID_WIDTH-1:0] m_axi_BID,
  output logic                m_axi_BREADY,
  output logic                aw_stall,
  output logic [7:0]          outstanding,
  output logic                busy,
  output logic                done,
  output logic                done_pulse,
  output logic                timeout,
  output logic [CNT_W-1:0]    resp_count,
  output logic [CNT_W-1:0]    err_count,
  output logic [1:0]          first_err_resp,
  output logic [ID_WIDTH-1:0] first_err_id,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                proto_err,
  output logic [7:0]          status_engine_id
);

  localparam logic [ID_WIDTH-1:0] EXP_BID_C = ID_WIDTH'(EXP_BID);
  localparam logic [CNT_W-1:0]    TOUT_C    = CNT_W'(TIMEOUT_CYCLES);

  wr_state_e        state, nxt;
  logic [CNT_W-1:0] write_ops_r;
  logic [CNT_W-1:0] idle_cnt;
  logic             b_fire;
  logic             resp_err;
  logic             in_run;
  logic             resp_last;
  logic             idle_hit;
  logic             underflow;

  // The B channel is always accepted so a misbehaving engine can never hang the bus.
  assign m_axi_BREADY     = 1'b1;
  assign b_fire           = m_axi_BVALID & m_axi_BREADY;
  assign resp_err         = is_err_resp(m_axi_BRESP) || (m_axi_BID != EXP_BID_C);
  assign in_run           = (state == ST_RUN);
  assign resp_last        = b_fire && ((resp_count + 32'd1) == write_ops_r);
  assign idle_hit         = (TIMEOUT_CYCLES != 0) && !aw_fire && !b_fire &&
                            (outstanding != 8'd0) && ((idle_cnt + 32'd1) == TOUT_C);
  assign status_engine_id = 8'(ENGINE_ID);

  // The credit count is bus state, so a restart does not clear it.
  hbm_credit_ctr #(
    .LIMIT(MAX_OUTSTANDING)
  ) u_credit (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (aw_fire),
    .dec      (b_fire),
    .count    (outstanding),
    .at_limit (aw_stall),
    .underflow(underflow)
  );

  // Next-state decode; start_write overrides every state.
  always_comb begin
    // NOTE: nxt gets a default first so no path through this block can infer a latch.
    nxt = state;
    if (start_write) begin
      nxt = ST_RUN;
    end else if (state == ST_RUN) begin
      if (write_ops_r == '0 || resp_last) nxt = ST_DONE;
      else if (idle_hit)                  nxt = ST_TOUT;
    end
  end

  // State, registered status outputs and run counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      done_pulse     <= 1'b0;
      timeout        <= 1'b0;
      proto_err      <= 1'b0;
      write_ops_r    <= '0;
      idle_cnt       <= '0;
      resp_count     <= '0;
      err_count      <= '0;
      cycle_count    <= '0;
      first_err_resp <= '0;
      first_err_id   <= '0;
    end else begin
      state      <= nxt;
      busy       <= (nxt == ST_RUN);
      done       <= (nxt == ST_DONE) || (nxt == ST_TOUT);
      done_pulse <= in_run && ((nxt == ST_DONE) || (nxt == ST_TOUT));
      if (start_write) begin
        write_ops_r    <= write_ops;
        idle_cnt       <= '0;
        resp_count     <= '0;
        err_count      <= '0;
        cycle_count    <= '0;
        first_err_resp <= '0;
        first_err_id   <= '0;
        timeout        <= 1'b0;
        proto_err      <= 1'b0;
      end else begin
        if (in_run && nxt == ST_TOUT) timeout <= 1'b1;
        if (b_fire && (!in_run || underflow)) proto_err <= 1'b1;
        if (in_run) begin
          cycle_count <= cycle_count + 32'd1;
          idle_cnt    <= (aw_fire || b_fire) ? '0 : idle_cnt + 32'd1;
          if (b_fire) begin
            resp_count <= resp_count + 32'd1;
            if (resp_err) begin
              err_count <= err_count + 32'd1;
              if (err_count == '0) begin
                first_err_resp <= m_axi_BRESP;
                first_err_id   <= m_axi_BID;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hbm_write_resp_monitor.sv
// Directed bench for hbm_write_resp_monitor: a main instance (credit 8, timeout 16)
// and a small-credit instance (credit 2, timeout off) share the same stimulus.
module tb_hbm_write_resp_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_write = 1'b0;
  logic [31:0] write_ops = '0;
  logic        aw_fire = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic [4:0]  bid = '0;

  logic        m_bready, m_stall, m_busy, m_done, m_pulse, m_tout, m_proto;
  logic [7:0]  m_out, m_eid;
  logic [31:0] m_resp, m_err, m_cyc;
  logic [1:0]  m_fe_resp;
  logic [4:0]  m_fe_id;

  logic        s_bready, s_stall, s_busy, s_done, s_pulse, s_tout, s_proto;
  logic [7:0]  s_out, s_eid;
  logic [31:0] s_resp, s_err, s_cyc;
  logic [1:0]  s_fe_resp;
  logic [4:0]  s_fe_id;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hbm_write_resp_monitor #(
    .ENGINE_ID(0), .ID_WIDTH(5), .EXP_BID(0), .MAX_OUTSTANDING(8), .TIMEOUT_CYCLES(16)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .start_write(start_write), .write_ops(write_ops),
    .aw_fire(aw_fire), .m_axi_BVALID(bvalid), .m_axi_BRESP(bresp), .m_axi_BID(bid),
    .m_axi_BREADY(m_bready), .aw_stall(m_stall), .outstanding(m_out), .busy(m_busy),
    .done(m_done), .done_pulse(m_pulse), .timeout(m_tout), .resp_count(m_resp),
    .err_count(m_err), .first_err_resp(m_fe_resp), .first_err_id(m_fe_id),
    .cycle_count(m_cyc), .proto_err(m_proto), .status_engine_id(m_eid)
  );

  hbm_write_resp_monitor #(
    .ENGINE_ID(3), .ID_WIDTH(5), .EXP_BID(0), .MAX_OUTSTANDING(2), .TIMEOUT_CYCLES(0)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start_write(start_write), .write_ops(write_ops),
    .aw_fire(aw_fire), .m_axi_BVALID(bvalid), .m_axi_BRESP(bresp), .m_axi_BID(bid),
    .m_axi_BREADY(s_bready), .aw_stall(s_stall), .outstanding(s_out), .busy(s_busy),
    .done(s_done), .done_pulse(s_pulse), .timeout(s_tout), .resp_count(s_resp),
    .err_count(s_err), .first_err_resp(s_fe_resp), .first_err_id(s_fe_id),
    .cycle_count(s_cyc), .proto_err(s_proto), .status_engine_id(s_eid)
  );

  // One clock; outputs are inspected 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic aw, input logic bv, input logic [1:0] r, input logic [4:0] id);
    aw_fire = aw; bvalid = bv; bresp = r; bid = id;
    step();
    aw_fire = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
  endtask

  task automatic do_start(input logic [31:0] n);
    start_write = 1'b1; write_ops = n;
    step();
    start_write = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    tests_run++; if (m_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0h want 0", m_busy); end
    tests_run++; if (m_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %0h want 0", m_done); end
    tests_run++; if (m_out !== 8'd0) begin tests_failed++; $display("FAIL reset_outstanding: got %0d want 0", m_out); end
    tests_run++; if (m_resp !== 32'd0) begin tests_failed++; $display("FAIL reset_resp_count: got %0d want 0", m_resp); end
    tests_run++; if (m_proto !== 1'b0) begin tests_failed++; $display("FAIL reset_proto_err: got %0h want 0", m_proto); end
    tests_run++; if (m_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_aw_stall: got %0h want 0", m_stall); end
    tests_run++; if (m_bready !== 1'b1 || s_bready !== 1'b1) begin tests_failed++; $display("FAIL reset_bready: got %0h/%0h want 1/1", m_bready, s_bready); end
    tests_run++; if (s_eid !== 8'd3) begin tests_failed++; $display("FAIL engine_id: got %0d want 3", s_eid); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_start(32'd4);
    tests_run++; if (m_busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy: got %0h want 1", m_busy); end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 2'b00, 5'd0); step(); end
    tests_run++; if (m_out !== 8'd4) begin tests_failed++; $display("FAIL basic_outstanding_4: got %0d want 4", m_out); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 2'b00, 5'd0);
      if (i < 3) step();
    end
    tests_run++; if (m_done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %0h want 1", m_done); end
    tests_run++; if (m_pulse !== 1'b1) begin tests_failed++; $display("FAIL basic_done_pulse: got %0h want 1", m_pulse); end
    tests_run++; if (m_resp !== 32'd4) begin tests_failed++; $display("FAIL basic_resp_count: got %0d want 4", m_resp); end
    tests_run++; if (m_err !== 32'd0) begin tests_failed++; $display("FAIL basic_err_count: got %0d want 0", m_err); end
    tests_run++; if (m_out !== 8'd0) begin tests_failed++; $display("FAIL basic_outstanding_0: got %0d want 0", m_out); end
    step();
    tests_run++; if (m_pulse !== 1'b0 || m_done !== 1'b1) begin tests_failed++; $display("FAIL basic_pulse_once: got pulse=%0h done=%0h want 0/1", m_pulse, m_done); end
  endtask

  task automatic test_credit();
    do_start(32'd8);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    tests_run++; if (s_stall !== 1'b0) begin tests_failed++; $display("FAIL credit_stall_after_1: got %0h want 0", s_stall); end
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    tests_run++; if (s_stall !== 1'b1 || s_out !== 8'd2) begin tests_failed++; $display("FAIL credit_stall_after_2: got stall=%0h out=%0d want 1/2", s_stall, s_out); end
    drive(~s_stall, 1'b0, 2'b00, 5'd0);
    tests_run++; if (s_out !== 8'd2) begin tests_failed++; $display("FAIL credit_held: got %0d want 2", s_out); end
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    tests_run++; if (s_stall !== 1'b0 || s_out !== 8'd1) begin tests_failed++; $display("FAIL credit_release: got stall=%0h out=%0d want 0/1", s_stall, s_out); end
    drive(1'b0, 1'b1, 2'b00, 5'd0);
  endtask

  task automatic test_errors();
    do_start(32'd3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    drive(1'b0, 1'b1, 2'b10, 5'd0);
    tests_run++; if (m_err !== 32'd1 || m_done !== 1'b0) begin tests_failed++; $display("FAIL err_slverr: got err=%0d done=%0h want 1/0", m_err, m_done); end
    drive(1'b0, 1'b1, 2'b11, 5'd0);
    tests_run++; if (m_err !== 32'd2) begin tests_failed++; $display("FAIL err_count: got %0d want 2", m_err); end
    tests_run++; if (m_fe_resp !== 2'b10) begin tests_failed++; $display("FAIL err_first_resp: got %0b want 10", m_fe_resp); end
    tests_run++; if (m_done !== 1'b1 || m_resp !== 32'd3) begin tests_failed++; $display("FAIL err_done: got done=%0h resp=%0d want 1/3", m_done, m_resp); end
    // Stray response after completion.
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    tests_run++; if (m_proto !== 1'b1 || m_resp !== 32'd3 || m_out !== 8'd0) begin tests_failed++; $display("FAIL stray_b: got proto=%0h resp=%0d out=%0d want 1/3/0", m_proto, m_resp, m_out); end
    // BID mismatch and EXOKAY.
    do_start(32'd2);
    tests_run++; if (m_proto !== 1'b0 || m_err !== 32'd0) begin tests_failed++; $display("FAIL start_clears: got proto=%0h err=%0d want 0/0", m_proto, m_err); end
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b0, 1'b1, 2'b00, 5'd3);
    tests_run++; if (m_err !== 32'd1 || m_fe_id !== 5'd3 || m_fe_resp !== 2'b00) begin tests_failed++; $display("FAIL bid_mismatch: got err=%0d id=%0d resp=%0b want 1/3/00", m_err, m_fe_id, m_fe_resp); end
    drive(1'b0, 1'b1, 2'b01, 5'd0);
    tests_run++; if (m_err !== 32'd2 || m_fe_id !== 5'd3 || m_done !== 1'b1) begin tests_failed++; $display("FAIL exokay: got err=%0d id=%0d done=%0h want 2/3/1", m_err, m_fe_id, m_done); end
  endtask

  task automatic test_same_cycle();
    do_start(32'd10);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'b00, 5'd0);
    tests_run++; if (m_out !== 8'd5) begin tests_failed++; $display("FAIL same_pre: got %0d want 5", m_out); end
    drive(1'b1, 1'b1, 2'b00, 5'd0);
    tests_run++; if (m_out !== 8'd5 || m_resp !== 32'd1) begin tests_failed++; $display("FAIL same_cycle: got out=%0d resp=%0d want 5/1", m_out, m_resp); end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 2'b00, 5'd0);
    tests_run++; if (m_out !== 8'd0 || m_proto !== 1'b0) begin tests_failed++; $display("FAIL drain: got out=%0d proto=%0h want 0/0", m_out, m_proto); end
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    tests_run++; if (m_out !== 8'd0 || m_proto !== 1'b1 || m_resp !== 32'd7) begin tests_failed++; $display("FAIL underflow: got out=%0d proto=%0h resp=%0d want 0/1/7", m_out, m_proto, m_resp); end
  endtask

  task automatic test_timeout();
    do_start(32'd4);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) begin
        tests_run++; if (m_tout !== 1'b0 || m_busy !== 1'b1) begin tests_failed++; $display("FAIL tout_early: got tout=%0h busy=%0h want 0/1", m_tout, m_busy); end
      end
    end
    tests_run++; if (m_tout !== 1'b1 || m_pulse !== 1'b1 || m_done !== 1'b1) begin tests_failed++; $display("FAIL tout_entry: got tout=%0h pulse=%0h done=%0h want 1/1/1", m_tout, m_pulse, m_done); end
    tests_run++; if (m_out !== 8'd1 || m_resp !== 32'd1 || m_cyc !== 32'd19) begin tests_failed++; $display("FAIL tout_counts: got out=%0d resp=%0d cyc=%0d want 1/1/19", m_out, m_resp, m_cyc); end
    step();
    tests_run++; if (m_pulse !== 1'b0 || m_tout !== 1'b1 || m_cyc !== 32'd19) begin tests_failed++; $display("FAIL tout_hold: got pulse=%0h tout=%0h cyc=%0d want 0/1/19", m_pulse, m_tout, m_cyc); end
    drive(1'b0, 1'b1, 2'b00, 5'd0);
  endtask

  task automatic test_back_to_back();
    do_start(32'd8);
    for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b0, 2'b00, 5'd0); drive(1'b0, 1'b1, 2'b00, 5'd0); end
    tests_run++; if (m_resp !== 32'd3 || m_out !== 8'd0) begin tests_failed++; $display("FAIL restart_pre: got resp=%0d out=%0d want 3/0", m_resp, m_out); end
    do_start(32'd8);
    tests_run++; if (m_resp !== 32'd0 || m_cyc !== 32'd0 || m_busy !== 1'b1 || m_tout !== 1'b0) begin tests_failed++; $display("FAIL restart_clear: got resp=%0d cyc=%0d busy=%0h tout=%0h want 0/0/1/0", m_resp, m_cyc, m_busy, m_tout); end
    for (int i = 0; i < 8; i++) begin drive(1'b1, 1'b0, 2'b00, 5'd0); drive(1'b0, 1'b1, 2'b00, 5'd0); end
    tests_run++; if (m_done !== 1'b1 || m_pulse !== 1'b1 || m_resp !== 32'd8 || m_out !== 8'd0) begin tests_failed++; $display("FAIL restart_done: got done=%0h pulse=%0h resp=%0d out=%0d want 1/1/8/0", m_done, m_pulse, m_resp, m_out); end
  endtask

  task automatic test_zero_ops();
    do_start(32'd0);
    tests_run++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin tests_failed++; $display("FAIL zero_run: got busy=%0h done=%0h want 1/0", m_busy, m_done); end
    step();
    tests_run++; if (m_done !== 1'b1 || m_pulse !== 1'b1 || m_busy !== 1'b0 || m_resp !== 32'd0) begin tests_failed++; $display("FAIL zero_done: got done=%0h pulse=%0h busy=%0h resp=%0d want 1/1/0/0", m_done, m_pulse, m_busy, m_resp); end
  endtask

  task automatic test_reset_midrun();
    do_start(32'd5);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b1, 1'b0, 2'b00, 5'd0);
    drive(1'b0, 1'b1, 2'b00, 5'd0);
    tests_run++; if (m_busy !== 1'b1 || m_out !== 8'd1) begin tests_failed++; $display("FAIL midrun_pre: got busy=%0h out=%0d want 1/1", m_busy, m_out); end
    rst_n = 1'b0;
    step();
    tests_run++; if (m_busy !== 1'b0 || m_out !== 8'd0 || m_resp !== 32'd0 || m_cyc !== 32'd0 || m_done !== 1'b0) begin tests_failed++; $display("FAIL midrun_reset: got busy=%0h out=%0d resp=%0d cyc=%0d done=%0h want 0/0/0/0/0", m_busy, m_out, m_resp, m_cyc, m_done); end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_errors();
    test_same_cycle();
    test_timeout();
    test_back_to_back();
    test_zero_ops();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
